// File: rtl/audio_interp_feeder_if.sv
// audio_interp_feeder_if: valid/ready sample handshake into the interpolating feeder
interface audio_interp_feeder_if #(parameter int A = 8);
    logic signed [A-1:0] in_sample;
    logic                in_valid;
    logic                in_ready;
    modport master (output in_sample, in_valid, input in_ready);
    modport slave (input in_sample, in_valid, output in_ready);
endinterface

// File: rtl/audio_interp_feeder.sv
// audio_interp_feeder: 2-entry sample FIFO feeding a per-clock linear interpolator
// Optional TEST_TONE_EN adds tone_en, replacing the FIFO with an internal +/-2^(A-2) triangle source.
module audio_interp_feeder #(
    parameter int A        = 8,
    parameter int S        = 4,
    parameter int STEP_DIV = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    audio_interp_feeder_if.slave bus,
`ifdef TEST_TONE_EN
    input  logic                tone_en,
`endif
    input  logic                clr_underrun,
    output logic signed [A-1:0] audio,
    output logic                sample_tick,
    output logic                underrun
);
    localparam int DW = $clog2(STEP_DIV);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t              state, state_nx;
    logic signed [A-1:0] mem [2];
    logic                rd;
    logic [1:0]          count, count_nx;
    logic [DW-1:0]       div_cnt;
    logic [S-1:0]        step_idx;
    logic signed [A-1:0] prev, cur, ld_val;
    logic signed [A:0]   diff;
    logic signed [A+S:0] prod;
    logic                tone, div_wrap, boundary, avail, load, starve, push, pop;
`ifdef TEST_TONE_EN
    localparam logic signed [A-1:0] Q = A'(1 << (A-2));
    logic tone_ph;
    assign tone   = tone_en;
    assign ld_val = tone ? (tone_ph ? -Q : Q) : mem[rd];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tone_ph <= 1'b0;
        else if (load && tone) tone_ph <= ~tone_ph;
`else
    assign tone   = 1'b0;
    assign ld_val = mem[rd];
`endif
    assign div_wrap = div_cnt == DW'(STEP_DIV - 1);
    assign boundary = state != IDLE && div_wrap && step_idx == '1;
    assign avail    = tone || count != 2'd0;
    assign load     = avail && (state == IDLE || boundary);
    assign starve   = boundary && !avail;
    assign pop      = load && !tone;
    assign push     = bus.in_valid && bus.in_ready && !tone;
    assign count_nx = count + 2'(push) - 2'(pop);
    // Widen before multiplying so diff*step_idx cannot overflow; floor via arithmetic shift
    assign diff = {cur[A-1], cur} - {prev[A-1], prev};
    assign prod = $signed({{S{diff[A]}}, diff}) * $signed({{(A+1){1'b0}}, step_idx});
    always_comb begin
        state_nx = load ? RUN : starve ? HOLD : state;
    end
    always_ff @(posedge clk)
        if (push) mem[rd ^ count[0]] <= bus.in_sample;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= 2'd0;
            rd           <= 1'b0;
            bus.in_ready <= 1'b0;
            div_cnt      <= '0;
            step_idx     <= '0;
            prev         <= '0;
            cur          <= '0;
            audio        <= '0;
            sample_tick  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            bus.in_ready <= !tone && count_nx != 2'd2;
            if (pop) rd <= ~rd;
            div_cnt      <= state == IDLE || div_wrap ? '0 : div_cnt + DW'(1);
            step_idx     <= state == IDLE ? '0 : div_wrap ? step_idx + S'(1) : step_idx;
            if (load || starve) prev <= state == IDLE ? '0 : cur;
            if (load) cur <= ld_val;
            audio        <= state == IDLE ? '0 : A'(prev + (prod >>> S));
            sample_tick  <= load || starve;
            underrun     <= starve ? 1'b1 : clr_underrun ? 1'b0 : underrun;
        end
    end
endmodule

// File: tb/tb_audio_interp_feeder.sv
// tb_audio_interp_feeder: directed + random stimulus against a queue/arithmetic reference model
module tb_audio_interp_feeder;
    localparam int A = 8, S = 4, SD = 16, PER = SD * (1 << S);
    logic clk = 1'b0, rst_n = 1'b0, clr_underrun = 1'b0;
    logic signed [A-1:0] audio;
    logic sample_tick, underrun;
    int n_chk = 0, n_fail = 0;
    audio_interp_feeder_if #(.A(A)) bus ();
    audio_interp_feeder #(.A(A), .S(S), .STEP_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_underrun(clr_underrun),
        .audio(audio), .sample_tick(sample_tick), .underrun(underrun));
    always #5 clk = ~clk;

    int q[$];
    int m_prev = 0, m_cur = 0, m_t = 0, m_audio = 0;
    bit m_run = 0, m_tick = 0, m_und = 0, m_rdy = 0, m_pushed = 0;

    function automatic int fdiv(input int p, input int d);
        return p >= 0 ? p / d : -((-p + d - 1) / d);
    endfunction

    // Sample period = PER clocks measured from the first load; output is prev + floor((cur-prev)*k/2^S)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_prev = 0; m_cur = 0; m_t = 0; m_audio = 0;
            m_run = 0; m_tick = 0; m_und = 0; m_rdy = 0; m_pushed = 0;
        end else begin
            bit bnd, ld;
            int k;
            k = (m_t % PER) / SD;
            m_audio = m_run ? m_prev + fdiv((m_cur - m_prev) * k, 1 << S) : 0;
            bnd = m_run && (m_t % PER == PER - 1);
            ld = q.size() > 0 && (!m_run || bnd);
            m_pushed = bus.in_valid && m_rdy;
            m_tick = ld || bnd;
            if (bnd && !ld) m_und = 1;
            else if (clr_underrun) m_und = 0;
            if (bnd) m_prev = m_cur;
            if (ld) m_cur = q.pop_front();
            m_t = (ld && !m_run) ? 0 : m_t + 1;
            m_run = m_run || ld;
            if (m_pushed) q.push_back(int'(bus.in_sample));
            m_rdy = q.size() != 2;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("audio", audio, m_audio);
        chk("sample_tick", sample_tick, m_tick);
        chk("underrun", underrun, m_und);
        chk("in_ready", bus.in_ready, m_rdy);
    endtask

    task automatic push(input int v);
        bit done = 0;
        bus.in_sample = A'(v);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4 * PER && !done; i++) begin
            step();
            done = m_pushed;
        end
        if (!done) chk("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_sample = 8'sd64;
        run(3);
        chk("reset_audio", audio, 0);
        chk("reset_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        push(64);
        push(-64);
        push(127);
        push(-128);
        run(5 * PER);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        step();
        chk("underrun_cleared", underrun, 0);
        push(50);
        clr_underrun = 1'b1;
        run(2 * PER + 8);
        clr_underrun = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = $urandom_range(0, 99) < 5;
            bus.in_sample = A'($urandom);
            clr_underrun = $urandom_range(0, 199) == 0;
            step();
        end
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = $urandom_range(0, 999) < 3;
            bus.in_sample = A'($urandom);
            clr_underrun = $urandom_range(0, 299) == 0;
            step();
        end
        bus.in_valid = 1'b0;
        clr_underrun = 1'b0;
        push(-100);
        push(90);
        run(PER / 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_audio", audio, 0);
        chk("midrst_tick", sample_tick, 0);
        chk("midrst_underrun", underrun, 0);
        chk("midrst_ready", bus.in_ready, 0);
        run(2);
        rst_n = 1'b1;
        push(-100);
        run(2 * PER);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_interp_feeder.md
Name: audio_interp_feeder

Overview:
- Upstream neighbour of the FM modulator; drives its signed audio input.
- Accepts low-rate signed audio samples through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Produces a linearly interpolated signed audio word every clock, so the modulator sees a smooth ramp instead of a staircase.
- Reports FIFO underrun and marks each sample-period boundary.

Parameters:
- A, 8, audio width in bits (two's complement), matches modulator A.
- S, 4, log2 of interpolation steps per sample period (2^S steps).
- STEP_DIV, 16, clocks per interpolation step (>=2); sample period = STEP_DIV*2^S clocks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_sample  in  A  signed input sample
- in_valid  in  1  in_sample valid
- in_ready  out  1  FIFO can accept
- clr_underrun  in  1  clears underrun flag
- audio  out  A  signed interpolated audio, registered
- sample_tick  out  1  one-cycle pulse at each sample-period boundary
- underrun  out  1  sticky underrun flag

Behaviour:
- Reset (async, rst_n=0):
  - audio=0, sample_tick=0, underrun=0, in_ready=0.
  - FIFO empty; prev=0, cur=0; div_cnt=0, step_idx=0; state=IDLE.
  - in_ready rises the first clock after rst_n deasserts.
- Handshake and FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !(count==2), registered-count based; a pop in the same cycle does not enable a push while full.
  - Push and pop in one cycle are both honoured (count unchanged).
  - FIFO order is strictly FIFO.
- Counters:
  - div_cnt counts 0..STEP_DIV-1.
  - At div_cnt wrap, step_idx increments modulo 2^S.
  - Boundary = div_cnt==STEP_DIV-1 && step_idx==2^S-1.
- States:
  - IDLE: counters held at 0, audio=0. When the FIFO is non-empty: pop into cur, prev keeps 0, go RUN, counters restart at 0, sample_tick=1.
  - RUN: at each boundary:
    - FIFO non-empty: prev<=cur, cur<=pop, sample_tick=1.
    - FIFO empty: prev<=cur, cur unchanged, underrun<=1, sample_tick=1, go HOLD.
  - HOLD: counters keep running; output equals cur (prev==cur). At each boundary, if the FIFO is non-empty, do the RUN load and return to RUN; otherwise stay in HOLD (underrun stays 1).
- Arithmetic:
  - diff = cur - prev in A+1 bits, signed.
  - prod = diff*step_idx in A+1+S bits.
  - interp = prev + (prod >>> S), arithmetic shift, i.e. floor.
  - Result always lies between prev and cur, so there is no saturation and it fits in A bits.
- Latency: audio is registered. It reflects prev, cur and step_idx of the previous cycle (1 clock).
- underrun flag: cleared by clr_underrun. A set in the same cycle as a clear takes priority over the clear.
- Mid-operation reset: everything returns to reset values immediately; buffered samples are discarded.

Optional Feature:
- Macro TEST_TONE_EN.
- Defined: adds input port tone_en (1 bit).
  - When tone_en=1, the FIFO is ignored and in_ready=0.
  - The interpolator is fed an internal alternating sequence +2^(A-2), -2^(A-2) at each boundary, giving a triangle wave of period 2*STEP_DIV*2^S clocks.
  - underrun is not set while tone_en=1.
- Not defined: port absent, no tone logic, behaviour as above.

Test Plan (defaults A=8, S=4, STEP_DIV=16, period 256 clocks):
- Reset: hold rst_n=0, drive in_valid=1 -> audio=0, in_ready=0, underrun=0; after release in_ready=1 and the first sample is accepted the next clock.
- Ramp: push 64 -> sample_tick pulse, then audio rises 0,4,8,...; audio=32 while step_idx=8, and 60 at step 15.
- Negative slope: prev=64, cur=-64 -> at step_idx=8 audio=0; at step 15 audio=-56.
- Extreme: prev=127, cur=-128 -> no overflow; step 15 audio=127+floor(-3825/16)=-113.
- Backpressure: push 3 samples with no boundary -> in_ready=0 after 2; the third is held until the next boundary pop and is accepted the following clock.
- Underrun: stop pushing -> at the boundary underrun=1 and audio holds cur. A new push resumes RUN at the next boundary. clr_underrun pulse clears the flag. Simultaneous set and clear leaves it at 1.
